// File: rtl/ccu_snoop_arbiter.sv
// ccu_snoop_arbiter: shares one ACE snoop master port (AC/CR/CD) between the
// CCU write-path (idx 0) and read-path (idx 1) snoop requesters. CR and CD
// responses are steered back to the issuing requester through in-order
// tracking FIFOs.
// Build option: define CCU_SNOOP_ARB_WR_PRIO_EN for fixed write-path priority
// instead of round-robin AC arbitration.
module ccu_snoop_arbiter #(
   parameter int unsigned AcAddrWidth    = 64,
   parameter int unsigned CdDataWidth    = 64,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   // requester side
   input  logic [1:0]                 slv_ac_valid_i,
   output logic [1:0]                 slv_ac_ready_o,
   input  logic [2*AcAddrWidth-1:0]   slv_ac_addr_i,
   input  logic [7:0]                 slv_ac_snoop_i,
   input  logic [5:0]                 slv_ac_prot_i,
   output logic [1:0]                 slv_cr_valid_o,
   input  logic [1:0]                 slv_cr_ready_i,
   output logic [4:0]                 slv_cr_resp_o,
   output logic [1:0]                 slv_cd_valid_o,
   input  logic [1:0]                 slv_cd_ready_i,
   output logic [CdDataWidth-1:0]     slv_cd_data_o,
   output logic                       slv_cd_last_o,
   // snoop master side
   output logic                       mst_ac_valid_o,
   input  logic                       mst_ac_ready_i,
   output logic [AcAddrWidth-1:0]     mst_ac_addr_o,
   output logic [3:0]                 mst_ac_snoop_o,
   output logic [2:0]                 mst_ac_prot_o,
   input  logic                       mst_cr_valid_i,
   output logic                       mst_cr_ready_o,
   input  logic [4:0]                 mst_cr_resp_i,
   input  logic                       mst_cd_valid_i,
   output logic                       mst_cd_ready_o,
   input  logic [CdDataWidth-1:0]     mst_cd_data_i,
   input  logic                       mst_cd_last_i,
   output logic                       err_o
);

   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(MaxOutstanding);

   typedef enum logic {AcIdle, AcHeld} ac_state_e;

   ac_state_e                 ac_state_q;
   logic                      lock_idx_q;
   logic                      ac_grant;
   logic                      ac_offer;
   logic                      ac_valid;
   logic                      ac_hs;

   logic [MaxOutstanding-1:0] cr_mem_q;
   logic [PtrW-1:0]           cr_wr_q, cr_rd_q;
   logic [CntW-1:0]           cr_cnt_q;
   logic                      cr_empty, cr_full, cr_head, cr_ready, cr_pop;

   logic [MaxOutstanding-1:0] cd_mem_q;
   logic [PtrW-1:0]           cd_wr_q, cd_rd_q;
   logic [CntW-1:0]           cd_cnt_q;
   logic                      cd_empty, cd_full, cd_head, cd_ready, cd_hs, cd_push, cd_pop;

   logic                      err_q;

`ifndef CCU_SNOOP_ARB_WR_PRIO_EN
   logic                      rr_q;
`endif

   assign cr_empty = (cr_cnt_q == '0);
   assign cr_full  = (cr_cnt_q == FullCnt);
   assign cd_empty = (cd_cnt_q == '0);
   assign cd_full  = (cd_cnt_q == FullCnt);
   assign cr_head  = cr_mem_q[cr_rd_q];
   assign cd_head  = cd_mem_q[cd_rd_q];

   // AC grant selection: a held grant wins, otherwise arbitrate among valid requesters
   always_comb begin
      ac_grant = 1'b0;
      if (ac_state_q == AcHeld) begin
         ac_grant = lock_idx_q;
      end else begin
`ifdef CCU_SNOOP_ARB_WR_PRIO_EN
         ac_grant = !slv_ac_valid_i[0] && slv_ac_valid_i[1];
`else
         if (&slv_ac_valid_i) ac_grant = rr_q;
         else                 ac_grant = slv_ac_valid_i[1];
`endif
      end
   end

   // AC offer, payload mux and per-requester ready; tracking full blocks the port
   always_comb begin
      ac_offer       = !rst_i && !cr_full;
      ac_valid       = ac_offer && slv_ac_valid_i[ac_grant];
      ac_hs          = ac_valid && mst_ac_ready_i;
      mst_ac_valid_o = ac_valid;
      mst_ac_addr_o  = ac_grant ? slv_ac_addr_i[2*AcAddrWidth-1:AcAddrWidth]
                                : slv_ac_addr_i[AcAddrWidth-1:0];
      mst_ac_snoop_o = ac_grant ? slv_ac_snoop_i[7:4] : slv_ac_snoop_i[3:0];
      mst_ac_prot_o  = ac_grant ? slv_ac_prot_i[5:3]  : slv_ac_prot_i[2:0];
      slv_ac_ready_o = 2'b00;
      slv_ac_ready_o[ac_grant] = mst_ac_ready_i && ac_offer;
   end

   // Grant lock: hold the granted index while AC is stalled by the master
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ac_state_q <= AcIdle;
         lock_idx_q <= 1'b0;
      end else begin
         lock_idx_q <= ac_grant;
         case (ac_state_q)
            AcIdle:  ac_state_q <= (ac_valid && !mst_ac_ready_i) ? AcHeld : AcIdle;
            AcHeld:  ac_state_q <= (ac_valid && !mst_ac_ready_i) ? AcHeld : AcIdle;
            default: ac_state_q <= AcIdle;
         endcase
      end
   end

`ifndef CCU_SNOOP_ARB_WR_PRIO_EN
   // Round-robin pointer moves to the other requester after every AC handshake
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)      rr_q <= 1'b0;
      else if (ac_hs) rr_q <= !ac_grant;
   end
`endif

   // CR/CD routing toward the owner at the head of each tracking FIFO
   always_comb begin
      cr_ready       = slv_cr_ready_i[cr_head] && !cr_empty;
      cr_pop         = mst_cr_valid_i && cr_ready;
      cd_push        = cr_pop && mst_cr_resp_i[0] && !cd_full;
      cd_ready       = slv_cd_ready_i[cd_head] && !cd_empty;
      cd_hs          = mst_cd_valid_i && cd_ready;
      cd_pop         = cd_hs && mst_cd_last_i;
      slv_cr_valid_o = 2'b00;
      slv_cr_valid_o[cr_head] = mst_cr_valid_i && !cr_empty;
      slv_cd_valid_o = 2'b00;
      slv_cd_valid_o[cd_head] = mst_cd_valid_i && !cd_empty;
      mst_cr_ready_o = cr_ready;
      mst_cd_ready_o = cd_ready;
   end

   assign slv_cr_resp_o = mst_cr_resp_i;
   assign slv_cd_data_o = mst_cd_data_i;
   assign slv_cd_last_o = mst_cd_last_i;
   assign err_o         = err_q;

   // CR tracking FIFO: owner index pushed on AC handshake, popped on CR handshake
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cr_mem_q <= '0;
         cr_wr_q  <= '0;
         cr_rd_q  <= '0;
         cr_cnt_q <= '0;
      end else begin
         if (ac_hs) begin
            cr_mem_q[cr_wr_q] <= ac_grant;
            cr_wr_q           <= cr_wr_q + PtrW'(1);
         end
         if (cr_pop) cr_rd_q <= cr_rd_q + PtrW'(1);
         if (ac_hs && !cr_pop)      cr_cnt_q <= cr_cnt_q + CntW'(1);
         else if (!ac_hs && cr_pop) cr_cnt_q <= cr_cnt_q - CntW'(1);
      end
   end

   // CD tracking FIFO: owner pushed on a DataTransfer CR, popped on the last CD beat
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cd_mem_q <= '0;
         cd_wr_q  <= '0;
         cd_rd_q  <= '0;
         cd_cnt_q <= '0;
      end else begin
         if (cd_push) begin
            cd_mem_q[cd_wr_q] <= cr_head;
            cd_wr_q           <= cd_wr_q + PtrW'(1);
         end
         if (cd_pop) cd_rd_q <= cd_rd_q + PtrW'(1);
         if (cd_push && !cd_pop)      cd_cnt_q <= cd_cnt_q + CntW'(1);
         else if (!cd_push && cd_pop) cd_cnt_q <= cd_cnt_q - CntW'(1);
      end
   end

   // Sticky error: response traffic arrived with no tracked owner
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) err_q <= 1'b0;
      else if ((mst_cr_valid_i && cr_empty) || (mst_cd_valid_i && cd_empty)) err_q <= 1'b1;
   end

endmodule

// File: tb/tb_ccu_snoop_arbiter.sv
// Directed bench for ccu_snoop_arbiter: a per-cycle vector table plus
// hand-written reset and error sequences.
module tb_ccu_snoop_arbiter;

   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;

   logic          clk_i, rst_i;
   logic [1:0]    slv_ac_valid_i, slv_ac_ready_o;
   logic [2*AW-1:0] slv_ac_addr_i;
   logic [7:0]    slv_ac_snoop_i;
   logic [5:0]    slv_ac_prot_i;
   logic [1:0]    slv_cr_valid_o, slv_cr_ready_i;
   logic [4:0]    slv_cr_resp_o;
   logic [1:0]    slv_cd_valid_o, slv_cd_ready_i;
   logic [DW-1:0] slv_cd_data_o;
   logic          slv_cd_last_o;
   logic          mst_ac_valid_o, mst_ac_ready_i;
   logic [AW-1:0] mst_ac_addr_o;
   logic [3:0]    mst_ac_snoop_o;
   logic [2:0]    mst_ac_prot_o;
   logic          mst_cr_valid_i, mst_cr_ready_o;
   logic [4:0]    mst_cr_resp_i;
   logic          mst_cd_valid_i, mst_cd_ready_o;
   logic [DW-1:0] mst_cd_data_i;
   logic          mst_cd_last_i;
   logic          err_o;

   ccu_snoop_arbiter #(.AcAddrWidth(AW), .CdDataWidth(DW), .MaxOutstanding(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .slv_ac_valid_i(slv_ac_valid_i), .slv_ac_ready_o(slv_ac_ready_o),
      .slv_ac_addr_i(slv_ac_addr_i), .slv_ac_snoop_i(slv_ac_snoop_i),
      .slv_ac_prot_i(slv_ac_prot_i),
      .slv_cr_valid_o(slv_cr_valid_o), .slv_cr_ready_i(slv_cr_ready_i),
      .slv_cr_resp_o(slv_cr_resp_o),
      .slv_cd_valid_o(slv_cd_valid_o), .slv_cd_ready_i(slv_cd_ready_i),
      .slv_cd_data_o(slv_cd_data_o), .slv_cd_last_o(slv_cd_last_o),
      .mst_ac_valid_o(mst_ac_valid_o), .mst_ac_ready_i(mst_ac_ready_i),
      .mst_ac_addr_o(mst_ac_addr_o), .mst_ac_snoop_o(mst_ac_snoop_o),
      .mst_ac_prot_o(mst_ac_prot_o),
      .mst_cr_valid_i(mst_cr_valid_i), .mst_cr_ready_o(mst_cr_ready_o),
      .mst_cr_resp_i(mst_cr_resp_i),
      .mst_cd_valid_i(mst_cd_valid_i), .mst_cd_ready_o(mst_cd_ready_o),
      .mst_cd_data_i(mst_cd_data_i), .mst_cd_last_i(mst_cd_last_i),
      .err_o(err_o)
   );

   typedef struct {
      logic [1:0]  acv;
      logic        acr;
      logic        crv;
      logic [1:0]  crr;
      logic [4:0]  resp;
      logic        cdv;
      logic [1:0]  cdr;
      logic        last;
      logic        e_acv;
      logic [15:0] e_addr;
      logic [1:0]  e_acr;
      logic [1:0]  e_crv;
      logic        e_crr;
      logic [1:0]  e_cdv;
      logic        e_cdr;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(input logic [1:0] acv, input logic acr, input logic crv,
                               input logic [1:0] crr, input logic [4:0] resp, input logic cdv,
                               input logic [1:0] cdr, input logic last, input logic e_acv,
                               input logic [15:0] e_addr, input logic [1:0] e_acr,
                               input logic [1:0] e_crv, input logic e_crr,
                               input logic [1:0] e_cdv, input logic e_cdr, input logic e_err);
      vec_t v;
      v.acv = acv; v.acr = acr; v.crv = crv; v.crr = crr; v.resp = resp;
      v.cdv = cdv; v.cdr = cdr; v.last = last;
      v.e_acv = e_acv; v.e_addr = e_addr; v.e_acr = e_acr; v.e_crv = e_crv;
      v.e_crr = e_crr; v.e_cdv = e_cdv; v.e_cdr = e_cdr; v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      slv_ac_valid_i = 2'b00; mst_ac_ready_i = 1'b0;
      mst_cr_valid_i = 1'b0;  slv_cr_ready_i = 2'b00; mst_cr_resp_i = 5'h00;
      mst_cd_valid_i = 1'b0;  slv_cd_ready_i = 2'b00; mst_cd_last_i = 1'b0;
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_ctl"}, 64'({mst_ac_valid_o, slv_ac_ready_o, slv_cr_valid_o, mst_cr_ready_o,
                              slv_cd_valid_o, mst_cd_ready_o}), 64'h0);
      chk({nm, "_err"}, 64'(err_o), 64'h0);
   endtask

   initial begin
      logic [8:0] act_ctl, exp_ctl;

      rst_i          = 1'b1;
      slv_ac_addr_i  = {64'h1000, 64'h2000};
      slv_ac_snoop_i = {4'h7, 4'h1};
      slv_ac_prot_i  = {3'h5, 3'h2};
      mst_cd_data_i  = 64'hCAFE_F00D_1234_5678;
      clear_inputs();

`ifdef CCU_SNOOP_ARB_WR_PRIO_EN
      vecs.push_back(mk(2'b11,1,0,2'b00,5'h0,0,2'b00,0, 1,16'h2000,2'b01, 2'b00,0,2'b00,0,0));
      vecs.push_back(mk(2'b11,1,0,2'b00,5'h0,0,2'b00,0, 1,16'h2000,2'b01, 2'b00,0,2'b00,0,0));
      vecs.push_back(mk(2'b11,1,0,2'b00,5'h0,0,2'b00,0, 1,16'h2000,2'b01, 2'b00,0,2'b00,0,0));
      vecs.push_back(mk(2'b10,0,0,2'b00,5'h0,0,2'b00,0, 1,16'h1000,2'b00, 2'b00,0,2'b00,0,0));
      vecs.push_back(mk(2'b11,0,0,2'b00,5'h0,0,2'b00,0, 1,16'h1000,2'b00, 2'b00,0,2'b00,0,0));
      vecs.push_back(mk(2'b11,1,0,2'b00,5'h0,0,2'b00,0, 1,16'h1000,2'b10, 2'b00,0,2'b00,0,0));
      vecs.push_back(mk(2'b11,1,0,2'b00,5'h0,0,2'b00,0, 0,16'h0000,2'b00, 2'b00,0,2'b00,0,0));
`else
      // round-robin build-up until the four tracking slots are full
      vecs.push_back(mk(2'b11,1,0,2'b00,5'h0,0,2'b00,0, 1,16'h2000,2'b01, 2'b00,0,2'b00,0,0));
      vecs.push_back(mk(2'b11,1,0,2'b00,5'h0,0,2'b00,0, 1,16'h1000,2'b10, 2'b00,0,2'b00,0,0));
      vecs.push_back(mk(2'b11,1,0,2'b00,5'h0,0,2'b00,0, 1,16'h2000,2'b01, 2'b00,0,2'b00,0,0));
      vecs.push_back(mk(2'b11,1,0,2'b00,5'h0,0,2'b00,0, 1,16'h1000,2'b10, 2'b00,0,2'b00,0,0));
      vecs.push_back(mk(2'b11,1,0,2'b00,5'h0,0,2'b00,0, 0,16'h0000,2'b00, 2'b00,0,2'b00,0,0));
      // CR pop while full still blocks AC that cycle; next cycle AC accepted
      vecs.push_back(mk(2'b11,1,1,2'b11,5'h01,0,2'b00,0, 0,16'h0000,2'b00, 2'b01,1,2'b00,0,0));
      vecs.push_back(mk(2'b11,1,0,2'b00,5'h0,0,2'b00,0, 1,16'h2000,2'b01, 2'b00,0,2'b00,0,0));
      // two-beat CD to idx0
      vecs.push_back(mk(2'b00,0,0,2'b00,5'h0,1,2'b11,0, 0,16'h0000,2'b00, 2'b00,0,2'b01,1,0));
      vecs.push_back(mk(2'b00,0,0,2'b00,5'h0,1,2'b11,1, 0,16'h0000,2'b00, 2'b00,0,2'b01,1,0));
      // drain CR in order 1,0(backpressured),0,1,0
      vecs.push_back(mk(2'b00,0,1,2'b10,5'h0,0,2'b00,0, 0,16'h0000,2'b00, 2'b10,1,2'b00,0,0));
      vecs.push_back(mk(2'b00,0,1,2'b10,5'h0,0,2'b00,0, 0,16'h0000,2'b00, 2'b01,0,2'b00,0,0));
      vecs.push_back(mk(2'b00,0,1,2'b01,5'h0,0,2'b00,0, 0,16'h0000,2'b00, 2'b01,1,2'b00,0,0));
      vecs.push_back(mk(2'b00,0,1,2'b11,5'h0,0,2'b00,0, 0,16'h0000,2'b00, 2'b10,1,2'b00,0,0));
      vecs.push_back(mk(2'b00,0,1,2'b11,5'h0,0,2'b00,0, 0,16'h0000,2'b00, 2'b01,1,2'b00,0,0));
      // idx1 alone moves RR pointer to 0, then grant lock holds idx1 against idx0
      vecs.push_back(mk(2'b10,1,0,2'b00,5'h0,0,2'b00,0, 1,16'h1000,2'b10, 2'b00,0,2'b00,0,0));
      vecs.push_back(mk(2'b10,0,0,2'b00,5'h0,0,2'b00,0, 1,16'h1000,2'b00, 2'b00,0,2'b00,0,0));
      vecs.push_back(mk(2'b11,0,0,2'b00,5'h0,0,2'b00,0, 1,16'h1000,2'b00, 2'b00,0,2'b00,0,0));
      vecs.push_back(mk(2'b11,0,0,2'b00,5'h0,0,2'b00,0, 1,16'h1000,2'b00, 2'b00,0,2'b00,0,0));
      vecs.push_back(mk(2'b11,1,0,2'b00,5'h0,0,2'b00,0, 1,16'h1000,2'b10, 2'b00,0,2'b00,0,0));
      vecs.push_back(mk(2'b01,1,0,2'b00,5'h0,0,2'b00,0, 1,16'h2000,2'b01, 2'b00,0,2'b00,0,0));
      vecs.push_back(mk(2'b00,0,1,2'b11,5'h0,0,2'b00,0, 0,16'h0000,2'b00, 2'b10,1,2'b00,0,0));
      vecs.push_back(mk(2'b00,0,1,2'b11,5'h0,0,2'b00,0, 0,16'h0000,2'b00, 2'b10,1,2'b00,0,0));
      // snoops idx0 (queued) and idx1; CR 0x01 to idx0, CR 0x00 to idx1, CD to idx0
      vecs.push_back(mk(2'b10,1,0,2'b00,5'h0,0,2'b00,0, 1,16'h1000,2'b10, 2'b00,0,2'b00,0,0));
      vecs.push_back(mk(2'b00,0,1,2'b11,5'h01,0,2'b00,0, 0,16'h0000,2'b00, 2'b01,1,2'b00,0,0));
      vecs.push_back(mk(2'b00,0,1,2'b11,5'h00,0,2'b00,0, 0,16'h0000,2'b00, 2'b10,1,2'b00,0,0));
      vecs.push_back(mk(2'b00,0,0,2'b00,5'h0,1,2'b11,0, 0,16'h0000,2'b00, 2'b00,0,2'b01,1,0));
      vecs.push_back(mk(2'b00,0,0,2'b00,5'h0,1,2'b11,1, 0,16'h0000,2'b00, 2'b00,0,2'b01,1,0));
      // orphan CR, then sticky error; orphan CD gets no ready
      vecs.push_back(mk(2'b00,0,1,2'b11,5'h0,0,2'b00,0, 0,16'h0000,2'b00, 2'b00,0,2'b00,0,0));
      vecs.push_back(mk(2'b00,0,0,2'b00,5'h0,0,2'b00,0, 0,16'h0000,2'b00, 2'b00,0,2'b00,0,1));
      vecs.push_back(mk(2'b00,0,0,2'b00,5'h0,1,2'b11,1, 0,16'h0000,2'b00, 2'b00,0,2'b00,0,1));
`endif

      // reset state, both during and after reset
      #2;
      chk_idle("rst_active");
      @(posedge clk_i); @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk_idle("idle_after_rst");
      @(posedge clk_i); #1;

      // vector table: drive after the edge, sample on the falling edge
      for (int i = 0; i < vecs.size(); i++) begin
         slv_ac_valid_i = vecs[i].acv;  mst_ac_ready_i = vecs[i].acr;
         mst_cr_valid_i = vecs[i].crv;  slv_cr_ready_i = vecs[i].crr;
         mst_cr_resp_i  = vecs[i].resp;
         mst_cd_valid_i = vecs[i].cdv;  slv_cd_ready_i = vecs[i].cdr;
         mst_cd_last_i  = vecs[i].last;
         @(negedge clk_i);
         act_ctl = {mst_ac_valid_o, slv_ac_ready_o, slv_cr_valid_o, mst_cr_ready_o,
                    slv_cd_valid_o, mst_cd_ready_o, err_o};
         exp_ctl = {vecs[i].e_acv, vecs[i].e_acr, vecs[i].e_crv, vecs[i].e_crr,
                    vecs[i].e_cdv, vecs[i].e_cdr, vecs[i].e_err};
         chk($sformatf("vec%0d_ctl", i), 64'(act_ctl), 64'(exp_ctl));
         if (vecs[i].e_acv)
            chk($sformatf("vec%0d_addr", i), mst_ac_addr_o, 64'(vecs[i].e_addr));
         if (vecs[i].e_cdv != 2'b00) begin
            chk($sformatf("vec%0d_cd_data", i), slv_cd_data_o, 64'hCAFE_F00D_1234_5678);
            chk($sformatf("vec%0d_cd_last", i), 64'(slv_cd_last_o), 64'(vecs[i].last));
         end
         if (vecs[i].e_crv != 2'b00)
            chk($sformatf("vec%0d_cr_resp", i), 64'(slv_cr_resp_o), 64'(vecs[i].resp));
         @(posedge clk_i); #1;
      end

      // reset clears the sticky error
      clear_inputs();
      rst_i = 1'b1;
      #1;
      chk_idle("err_cleared");
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      // orphan CD beat: no ready, error raised on the next edge
      mst_cd_valid_i = 1'b1; slv_cd_ready_i = 2'b11; mst_cd_last_i = 1'b1;
      @(negedge clk_i);
      chk("orphan_cd_ready", 64'({slv_cd_valid_o, mst_cd_ready_o}), 64'h0);
      @(posedge clk_i); #1;
      chk("orphan_cd_err", 64'(err_o), 64'h1);
      clear_inputs();

      // reset mid-operation with three snoops outstanding
      rst_i = 1'b1; #1; rst_i = 1'b0;
      @(posedge clk_i); #1;
      slv_ac_valid_i = 2'b11; mst_ac_ready_i = 1'b1;
      @(negedge clk_i);
      chk("first_grant_snoop", 64'({mst_ac_snoop_o, mst_ac_prot_o}), 64'({4'h1, 3'h2}));
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      mst_cr_valid_i = 1'b1; slv_cr_ready_i = 2'b11;
      #1;
      chk("pre_rst_cr_ready", 64'(mst_cr_ready_o), 64'h1);
      rst_i = 1'b1;
      #1;
      chk("rst_async_ctl", 64'({mst_ac_valid_o, slv_ac_ready_o, slv_cr_valid_o, mst_cr_ready_o}),
          64'h0);
      mst_cr_valid_i = 1'b0; slv_cr_ready_i = 2'b00;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      // tracking restarted from empty: exactly four more ACs fit
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         chk($sformatf("post_rst_ac%0d", k), 64'(mst_ac_valid_o), 64'h1);
         if (k == 0) chk("post_rst_addr", mst_ac_addr_o, 64'h2000);
         @(posedge clk_i); #1;
      end
      @(negedge clk_i);
      chk("post_rst_full", 64'({mst_ac_valid_o, slv_ac_ready_o}), 64'h0);
      clear_inputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
